// File: rtl/comb_truth_checker.sv
// comb_truth_checker: exhaustive stimulus/response engine for 3-input
// combinational blocks. Walks {A,B,C} through codes 000..111, holds each code
// for SETTLE cycles, samples Y once and compares it with EXPECTED[code].
//
// Handshake: start is a level sampled only in IDLE; a sweep begins on the
// rising edge where start=1 and the FSM is IDLE. busy is high from that edge
// until the edge that enters DONE. done is a single-cycle pulse in DONE.
// pass/err_count/fail_map hold their values from DONE until the next
// accepted start, which clears them.
module comb_truth_checker #(
  parameter logic [7:0] EXPECTED = 8'h00,
  parameter int         SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map,
  output logic [1:0] state_dbg
);

  // Settle time must fit the 4-bit down-counter and be at least one cycle.
  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("comb_truth_checker: SETTLE must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter reload so that SETTLE occupies exactly SETTLE cycles.
  localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_map;

  state_t     w_state_nxt;
  logic [2:0] w_vec_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [3:0] w_err_nxt;
  logic [7:0] w_map_nxt;

  logic       w_mismatch;
  logic [3:0] w_err_sample;
  logic [7:0] w_map_sample;

  // Result of comparing the current response with the expected table entry.
  always_comb begin
    w_mismatch   = (Y != EXPECTED[r_vec]);
    w_err_sample = r_err + {3'b000, w_mismatch};
    w_map_sample = r_map | (8'(w_mismatch) << r_vec);
  end

  // Next-state and next-datapath logic; every target holds unless changed.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_map_nxt   = r_map;
    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_vec_nxt   = 3'd0;
          w_err_nxt   = 4'd0;
          w_map_nxt   = 8'h00;
          w_pass_nxt  = 1'b0;
          w_cnt_nxt   = LP_RELOAD;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_err_nxt = w_err_sample;
        w_map_nxt = w_map_sample;
        if (r_vec == 3'd7) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_sample == 4'd0);
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_nxt   = r_vec + 3'd1;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_vec_nxt   = 3'd0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= 3'd0;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_map   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_map   <= w_map_nxt;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    {A, B, C}  = r_vec;
    busy       = r_busy;
    done       = r_done;
    pass       = r_pass;
    err_count  = r_err;
    fail_map   = r_map;
    state_dbg  = r_state;
  end

endmodule

// File: tb/tb_comb_truth_checker.sv
// Bench for comb_truth_checker: three instances (SETTLE 2, 1, 15) each checking
// a table-driven response function. Sweeps run one at a time; the driver
// pushes the expected result and timing, a negedge monitor checks every cycle.
module tb_comb_truth_checker;

  localparam int NI = 3;
  localparam logic [7:0] EXP_T [NI] = '{8'hEA, 8'h96, 8'h3C};
  localparam int         SET_T [NI] = '{2, 1, 15};
  localparam int W = 35; // {inst[2], accept[20], pass, err[4], map[8]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic       start_s [NI];
  logic [7:0] y_fn    [NI];
  logic       y_w     [NI];
  logic       a_w     [NI];
  logic       b_w     [NI];
  logic       c_w     [NI];
  logic       busy_w  [NI];
  logic       done_w  [NI];
  logic       pass_w  [NI];
  logic [3:0] err_w   [NI];
  logic [7:0] map_w   [NI];
  logic [1:0] st_w    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    comb_truth_checker #(
      .EXPECTED(EXP_T[g]),
      .SETTLE  (SET_T[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s[g]),
      .Y         (y_w[g]),
      .A         (a_w[g]),
      .B         (b_w[g]),
      .C         (c_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .pass      (pass_w[g]),
      .err_count (err_w[g]),
      .fail_map  (map_w[g]),
      .state_dbg (st_w[g])
    );
    // Block under check: a lookup table indexed by {A,B,C}.
    assign y_w[g] = y_fn[g][{a_w[g], b_w[g], c_w[g]}];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  logic [12:0]  last_res [NI];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  // Reference: mismatches are simply the XOR of observed and expected tables.
  task automatic push_sweep(input int inst, input logic [7:0] fn, input int acc);
    logic [7:0]   mism;
    logic [W-1:0] e;
    mism = fn ^ EXP_T[inst];
    e = {2'(inst), 20'(acc), (mism == 8'h00), 4'($countones(mism)), mism};
    exp_q.push_back(e);
  endtask

  // Truth table of Y = (A & B) | C, A is the MSB of the index.
  function automatic logic [7:0] and_or_table();
    logic [7:0] t;
    t = 8'h00;
    for (int v = 0; v < 8; v++) t[v] = 1'(((v / 4) % 2 & (v / 2) % 2) | (v % 2));
    return t;
  endfunction

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  int  mon_ai, mon_acc, mon_s, mon_k;
  bit  mon_act;

  always @(negedge clk) begin
    mon_act = 1'b0;
    mon_ai  = -1;
    mon_k   = 0;
    mon_s   = 1;
    mon_e   = '0;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q[0];
      mon_ai  = int'(mon_e[34:33]);
      mon_acc = int'(mon_e[32:13]);
      mon_s   = SET_T[mon_ai];
      mon_k   = cyc - mon_acc;
      mon_act = (mon_k >= 0);
    end
    for (int i = 0; i < NI; i++) begin
      if (mon_act && i == mon_ai) begin
        if (mon_k < 8 * (mon_s + 1)) begin
          chk("busy", i, 32'(busy_w[i]), 32'd1);
          chk("done_early", i, 32'(done_w[i]), 32'd0);
          chk("abc", i, 32'({a_w[i], b_w[i], c_w[i]}), mon_k / (mon_s + 1));
        end else begin
          chk("done", i, 32'(done_w[i]), 32'd1);
          chk("busy_done", i, 32'(busy_w[i]), 32'd0);
          chk("abc_done", i, 32'({a_w[i], b_w[i], c_w[i]}), 32'd7);
          chk("pass", i, 32'(pass_w[i]), 32'(mon_e[12]));
          chk("err_count", i, 32'(err_w[i]), 32'(mon_e[11:8]));
          chk("fail_map", i, 32'(map_w[i]), 32'(mon_e[7:0]));
          last_res[i] = mon_e[12:0];
          void'(exp_q.pop_front());
        end
      end else begin
        chk("busy_idle", i, 32'(busy_w[i]), 32'd0);
        chk("done_idle", i, 32'(done_w[i]), 32'd0);
        chk("abc_idle", i, 32'({a_w[i], b_w[i], c_w[i]}), 32'd0);
        chk("hold", i, 32'({pass_w[i], err_w[i], map_w[i]}), 32'(last_res[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input int inst, input logic [7:0] fn, input bit pulse_busy);
    int acc, len;
    @(negedge clk);
    y_fn[inst]    = fn;
    start_s[inst] = 1'b1;
    acc = cyc + 1;
    len = 8 * (SET_T[inst] + 1);
    push_sweep(inst, fn, acc);
    @(negedge clk);
    start_s[inst] = 1'b0;
    if (pulse_busy) begin
      // Extra start pulses, all landing well before the sweep ends.
      for (int p = 0; p < 4; p++) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start_s[inst] = 1'b1;
        @(negedge clk);
        start_s[inst] = 1'b0;
      end
    end
    while (cyc < acc + len + 2) @(negedge clk);
  endtask

  // start held high: a second sweep is accepted two edges after done.
  task automatic held_start(input int inst, input logic [7:0] fn);
    int acc1, acc2, len;
    @(negedge clk);
    y_fn[inst]    = fn;
    start_s[inst] = 1'b1;
    len  = 8 * (SET_T[inst] + 1);
    acc1 = cyc + 1;
    acc2 = acc1 + len + 2;
    push_sweep(inst, fn, acc1);
    push_sweep(inst, fn, acc2);
    while (cyc < acc2 + 3) @(negedge clk);
    start_s[inst] = 1'b0;
    while (cyc < acc2 + len + 2) @(negedge clk);
  endtask

  // Asynchronous reset while vector 3 is on the outputs.
  task automatic reset_mid(input logic [7:0] fn);
    int acc;
    @(negedge clk);
    y_fn[0]    = fn;
    start_s[0] = 1'b1;
    acc = cyc + 1;
    push_sweep(0, fn, acc);
    @(negedge clk);
    start_s[0] = 1'b0;
    while (cyc < acc + 3 * (SET_T[0] + 1) + 1) @(negedge clk);
    chk("abc_pre_reset", 0, 32'({a_w[0], b_w[0], c_w[0]}), 32'd3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NI; i++) last_res[i] = 13'd0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_abc", i, 32'({a_w[i], b_w[i], c_w[i]}), 32'd0);
      chk("rst_flags", i, 32'({busy_w[i], done_w[i], pass_w[i]}), 32'd0);
      chk("rst_err", i, 32'(err_w[i]), 32'd0);
      chk("rst_map", i, 32'(map_w[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int inst;
    logic [7:0] fn;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i]  = 1'b0;
      y_fn[i]     = 8'h00;
      last_res[i] = 13'd0;
    end
    // Reset with random start and response activity.
    repeat (4) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
        start_s[i] = 1'($urandom_range(0, 1));
        y_fn[i]    = 8'($urandom);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        chk("reset_abc", i, 32'({a_w[i], b_w[i], c_w[i]}), 32'd0);
        chk("reset_flags", i, 32'({busy_w[i], done_w[i], pass_w[i]}), 32'd0);
        chk("reset_err", i, 32'(err_w[i]), 32'd0);
        chk("reset_map", i, 32'(map_w[i]), 32'd0);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) start_s[i] = 1'b0;
    #2;
    rst_n = 1'b1;

    // Correct block, then stuck-at-0 and stuck-at-1.
    run_sweep(0, and_or_table(), 1'b0);
    run_sweep(0, 8'h00, 1'b0);
    run_sweep(0, 8'hFF, 1'b0);
    // Extra start pulses while busy, with mismatches accumulating.
    run_sweep(0, 8'h00, 1'b1);
    run_sweep(2, 8'h5A, 1'b1);
    // Back-to-back sweeps from a held start.
    held_start(0, 8'hE8);
    // Reset in the middle of a sweep, then a full correct sweep.
    reset_mid(8'h11);
    run_sweep(0, and_or_table(), 1'b0);
    // Shortest and longest settle times.
    run_sweep(1, EXP_T[1], 1'b0);
    run_sweep(1, 8'h69, 1'b0);
    run_sweep(2, EXP_T[2], 1'b0);
    // Random tables on random instances.
    for (int n = 0; n < 12; n++) begin
      inst = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 3) == 0) fn = EXP_T[inst];
      else fn = 8'($urandom);
      run_sweep(inst, fn, (inst != 1) && ($urandom_range(0, 1) == 1));
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/comb_truth_checker.md
Name: comb_truth_checker

Overview:
- Hardware stimulus/response engine for 3-input combinational blocks with the same A/B/C→Y interface as the team's comb_Y* modules.
- Drives {A,B,C} through all 8 codes 000→111 in ascending order and waits a programmable settle time after each code.
- Samples Y after the settle time and compares it against a parameterised expected truth table.
- Reports a pass flag, an error count and a per-vector failure map, so exhaustive checks run on-chip or in a self-checking bench.

Parameters:
- EXPECTED, 8'h00: expected truth table; bit i = expected Y when {A,B,C} = i (A is MSB).
- SETTLE, 2: cycles each vector is held before sampling; legal range 1..15, other values are an elaboration error.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- Y  input  1  response from the DUT under check.
- A  output  1  stimulus MSB, registered.
- B  output  1  stimulus middle bit, registered.
- C  output  1  stimulus LSB, registered.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  4  mismatch count of current/last sweep, 0..8.
- fail_map  output  8  bit i set if vector i mismatched.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; vec = 0; A = B = C = 0.
  - busy, done, pass = 0; err_count = 0; fail_map = 0; settle counter = 0.
- {A,B,C} always equals the registered vec[2:0].
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy = 0.
  - If start = 1 at a rising edge: vec ← 0; err_count ← 0; fail_map ← 0; pass ← 0; cnt ← SETTLE−1; busy ← 1; go to SETTLE.
- SETTLE:
  - If cnt ≠ 0, cnt decrements.
  - If cnt = 0, go to SAMPLE.
  - The state therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - Compare Y with EXPECTED[vec].
  - On mismatch: err_count += 1 and fail_map[vec] ← 1.
  - If vec = 7: go to DONE.
  - Otherwise: vec += 1, cnt ← SETTLE−1, go to SETTLE.
- DONE (one cycle):
  - done = 1 and busy = 0.
  - pass = (err_count = 0), including the vec-7 sample result.
  - Next state is IDLE; vec ← 0, so A/B/C return to 000.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done is high in the cycle following edge N = 8·(SETTLE+1), where edge 0 accepts start.
  - With SETTLE = 2, done follows edge 24.
- Holding: pass, err_count and fail_map hold after DONE until the next accepted start.
- start is ignored outside IDLE. start held high continuously causes back-to-back sweeps, each re-cleared at acceptance.
- err_count saturates naturally at 8; no wrap is possible.
- Y is sampled only in SAMPLE; its value in other states is don't-care.
- Reset asserted mid-sweep forces reset values immediately, with no done pulse. Operation resumes in IDLE after rst_n rises.

Test Plan:
1. Assert rst_n = 0 with random start/Y → A, B, C, busy, done, pass = 0; err_count = 0; fail_map = 8'h00.
2. Model Y = (A&B)|C, EXPECTED = 8'hEA, SETTLE = 2, single-cycle start pulse:
   - A/B/C walk 000→111, each held 3 cycles.
   - busy high for 24 cycles.
   - done pulses once after edge 24.
   - pass = 1, err_count = 0, fail_map = 8'h00.
   - A/B/C return to 000.
3. Same setup with Y stuck at 0 → err_count = 5, fail_map = 8'hEA, pass = 0. Then Y stuck at 1 and a second start → err_count = 3, fail_map = 8'h15.
4. Pulse start repeatedly while busy → exactly one done per sweep. Sweep length is unchanged at 24 cycles and counts are not cleared mid-sweep.
5. Drop rst_n asynchronously (between edges) while vec = 3 → outputs reach reset values before the next edge and no done appears. A new start after release runs a full, correct sweep.
6. SETTLE = 1 → each vector is held 2 cycles and done follows edge 16. SETTLE = 15 → done follows edge 128.
